fetch_queue: RTL

Instruction queue between instruction fetch and decode. It captures each fetched `{pc, instruction}` pair and presents the oldest pair to decode under a valid/ready handshake. It also discards all queued entries when a redirect (taken branch or register jump) is flushed. Fetch can then run ahead of decode stalls without losing or duplicating instructions.

---
 rtl/fetch_queue_if.sv | 60 ++++++
 rtl/fetch_queue.sv | 117 +++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue_if
// Description : Handshake bundle between instruction fetch, the fetch queue
//               and decode. The slave modport is the queue's view; the master
//               modport is the view of the surrounding fetch/decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_queue_if #(
  parameter int DEPTH     = 4,
  parameter int WORD      = 32,
  parameter int INSTR_LEN = 32
);
  localparam int CW = $clog2(DEPTH + 1);

  // Fetch side
  logic                 in_valid;
  logic                 in_ready;
  logic [WORD-1:0]      in_pc;
  logic [INSTR_LEN-1:0] in_instruction;

  // Redirect
  logic                 flush;

  // Decode side
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD-1:0]      out_pc;
  logic [INSTR_LEN-1:0] out_instruction;

  // Occupancy
  logic [CW-1:0]        count;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_pc,
    input  in_instruction,
    input  flush,
    output out_valid,
    input  out_ready,
    output out_pc,
    output out_instruction,
    output count
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_pc,
    output in_instruction,
    output flush,
    input  out_valid,
    output out_ready,
    input  out_pc,
    input  out_instruction,
    input  count
  );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Circular instruction queue between fetch and decode. Holds
//               {pc, instruction} pairs, presents the oldest to decode under a
//               valid/ready handshake and drops everything on a redirect flush.
//               Optional macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path
//               from in_* to out_* when the queue is empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH     = 4,
  parameter int WORD      = 32,
  parameter int INSTR_LEN = 32
) (
  input  wire           clk,
  input  wire           reset,   // asynchronous, active-low
  fetch_queue_if.slave  bus
);

  localparam int            PW     = $clog2(DEPTH);
  localparam int            CW     = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PW-1:0] C_STEP = PW'(1);

  // Storage: contents are never cleared, only the pointers/count are.
  logic [WORD-1:0]      pc_mem    [DEPTH];
  logic [INSTR_LEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic not_empty;
  logic not_full;
  logic push;
  logic pop;
  logic bypass_active;

  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != C_FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
  // An empty queue forwards the incoming pair straight to decode; if decode
  // takes it this cycle it is never written into storage.
  assign bypass_active = !not_empty && bus.in_valid && !bus.flush;
  assign push = bus.in_valid && not_full && !bus.flush && !(bypass_active && bus.out_ready);
`else
  assign bypass_active = 1'b0;
  assign push = bus.in_valid && not_full && !bus.flush;
`endif
  // Pops only ever come from storage; a bypassed pair is not a pop.
  assign pop = not_empty && bus.out_ready && !bus.flush;

  // Handshake and head outputs; out_* read as zero whenever nothing is valid.
  always_comb begin
    bus.in_ready        = not_full;
    bus.out_valid       = not_empty || bypass_active;
    bus.count           = count_q;
    bus.out_pc          = '0;
    bus.out_instruction = '0;
    if (not_empty) begin
      bus.out_pc          = pc_mem[rd_ptr_q];
      bus.out_instruction = instr_mem[rd_ptr_q];
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass_active) begin
      bus.out_pc          = bus.in_pc;
      bus.out_instruction = bus.in_instruction;
    end
`endif
  end

  // Next pointer/occupancy; flush wins over any push or pop in the same cycle.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + C_STEP;
      if (pop)  rd_ptr_d = rd_ptr_q + C_STEP;
      case ({push, pop})
        2'b10:   count_d = count_q + C_ONE;
        2'b01:   count_d = count_q - C_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry write at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.in_pc;
      instr_mem[wr_ptr_q] <= bus.in_instruction;
    end
  end

endmodule
`default_nettype wire
